// File: rtl/multi_voice_synth.sv
// N-voice tone generator with a sequential mixer, fed by a one-entry config slot.
// Define MULTI_VOICE_SYNTH_SINE_EN to build the sine LUT; otherwise wave 3 falls back to triangle.
module multi_voice_synth #(
  parameter int NUM_VOICES = 3,
  parameter int PRD_W      = 32,
  parameter int AMP_W      = 4,
  parameter int SAMPLE_DIV = 256,
  localparam int VSEL_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
  localparam int OUT_W     = AMP_W + $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [VSEL_W-1:0]     cfg_voice,
  input  logic [PRD_W-1:0]      cfg_period,
  input  logic [1:0]            cfg_wave,
  input  logic                  cfg_enable,
  output logic [OUT_W-1:0]      sample,
  output logic                  sample_valid,
  output logic [NUM_VOICES-1:0] active_voices
);

  localparam int STEP_W = PRD_W - 6;
  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam logic [AMP_W-1:0] AMP_MAX = '1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [DIV_W-1:0]  divCnt_q;
  logic              tick;
  logic              pendValid_q;
  logic [VSEL_W-1:0] pendVoice_q;
  logic [STEP_W-1:0] pendStep_q;
  logic [1:0]        pendWave_q;
  logic              pendEnable_q;
  logic              unusedPeriodLsbs;

  logic [STEP_W-1:0]     step_q  [NUM_VOICES];
  logic [1:0]            wave_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0] enable_q;
  logic [STEP_W-1:0]     cnt_q   [NUM_VOICES];
  logic [5:0]            phase_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] applyHit;
  logic [AMP_W-1:0]      amp     [NUM_VOICES];
  logic [AMP_W-1:0]      snap_q  [NUM_VOICES];

  logic [1:0]        state_q, state_d;
  logic [VSEL_W-1:0] idx_q;
  logic [OUT_W-1:0]  acc_q, sample_q, accSum;
  logic              valid_q, lastIdx;

  // The period only matters in units of 64 clocks, so the low bits are dropped at the slot.
  assign unusedPeriodLsbs = ^cfg_period[5:0];
  assign tick             = (divCnt_q == DIV_W'(SAMPLE_DIV - 1));
  assign cfg_ready        = ~pendValid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divCnt_q <= '0;
    end else if (tick) begin
      divCnt_q <= '0;
    end else begin
      divCnt_q <= divCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pendValid_q  <= 1'b0;
      pendVoice_q  <= '0;
      pendStep_q   <= '0;
      pendWave_q   <= '0;
      pendEnable_q <= 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      pendValid_q  <= 1'b1;
      pendVoice_q  <= cfg_voice;
      pendStep_q   <= cfg_period[PRD_W-1:6];
      pendWave_q   <= cfg_wave;
      pendEnable_q <= cfg_enable;
    end else if (tick) begin
      pendValid_q  <= 1'b0;
    end
  end

`ifdef MULTI_VOICE_SYNTH_SINE_EN
  function automatic int sineQuarter(input int k);
    case (k)
      0: return 0;      1: return 6424;   2: return 12785;  3: return 19024;
      4: return 25080;  5: return 30894;  6: return 36410;  7: return 41576;
      8: return 46341;  9: return 50661;  10: return 54492; 11: return 57798;
      12: return 60548; 13: return 62714; 14: return 64277; 15: return 65220;
      default: return 65536;
    endcase
  endfunction

  // sin is stored as a Q16 quarter wave; the full cycle is rebuilt by mirroring and negation.
  function automatic logic [AMP_W-1:0] sineEntry(input int p);
    int     k, s;
    longint num;
    k = p % 16;
    if (((p / 16) % 2) == 1) k = 16 - k;
    s = sineQuarter(k);
    if (p >= 32) s = -s;
    num = longint'((1 << AMP_W) - 1) * longint'(65536 + s) + 64'sd65536;
    return AMP_W'(num / 64'sd131072);
  endfunction

  logic [AMP_W-1:0] sineLut [64];
  always_comb begin
    for (int g = 0; g < 64; g++) sineLut[g] = sineEntry(g);
  end
`endif

  function automatic logic [AMP_W-1:0] waveAmp(input logic [1:0] wave, input logic [5:0] p);
    case (wave)
      2'd0:    return p[5] ? AMP_MAX : '0;
      2'd1:    return p[5 -: AMP_W];
      default: return p[5] ? ~p[4 -: AMP_W] : p[4 -: AMP_W];
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      applyHit[i] = tick && pendValid_q && (pendVoice_q == VSEL_W'(i));
      amp[i]      = '0;
      if (enable_q[i] && (step_q[i] != '0)) begin
        amp[i] = waveAmp(wave_q[i], phase_q[i]);
`ifdef MULTI_VOICE_SYNTH_SINE_EN
        if (wave_q[i] == 2'd3) amp[i] = sineLut[phase_q[i]];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        step_q[i]  <= '0;
        wave_q[i]  <= '0;
        cnt_q[i]   <= '0;
        phase_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (applyHit[i]) begin
          step_q[i]   <= pendStep_q;
          wave_q[i]   <= pendWave_q;
          enable_q[i] <= pendEnable_q;
          cnt_q[i]    <= '0;
          phase_q[i]  <= '0;
        end else if (step_q[i] != '0) begin
          if (cnt_q[i] == step_q[i] - 1'b1) begin
            cnt_q[i]   <= '0;
            phase_q[i] <= phase_q[i] + 6'd1;
          end else begin
            cnt_q[i]   <= cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  assign lastIdx = (idx_q == VSEL_W'(NUM_VOICES - 1));
  assign accSum  = acc_q + OUT_W'(snap_q[idx_q]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tick) state_d = S_ACC;
      S_ACC:   if (lastIdx) state_d = S_OUT;
      default: state_d = S_IDLE;
    endcase
  end

  // The final sum is registered on leaving ACC so the strobe coincides with the OUT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) snap_q[i] <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= 1'b0;
      if (state_q == S_IDLE && tick) begin
        for (int i = 0; i < NUM_VOICES; i++) snap_q[i] <= amp[i];
        acc_q <= '0;
        idx_q <= '0;
      end else if (state_q == S_ACC) begin
        acc_q <= accSum;
        idx_q <= idx_q + VSEL_W'(1);
        if (lastIdx) begin
          sample_q <= accSum;
          valid_q  <= 1'b1;
        end
      end
    end
  end

  assign sample        = sample_q;
  assign sample_valid  = valid_q;
  assign active_voices = enable_q;

endmodule
